writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/writeback_bypass_match.sv | 46 ++++
 rtl/writeback_queue.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared register-file definitions used by the writeback queue and its
// forwarding matcher.
//   NUM_REGS       : number of architectural registers
//   REG_ADDR_W     : register address width
//   REG_DATA_MAX_W : widest data word an entry can carry; a queue instance
//                    uses the low W bits and leaves the rest at zero
//   wb_entry_t     : one pending writeback {addr, data}
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int NUM_REGS       = 16;
    localparam int REG_ADDR_W     = $clog2(NUM_REGS);
    localparam int REG_DATA_MAX_W = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t                 addr;
        logic [REG_DATA_MAX_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_bypass_match.sv
// ---------------------------------------------------------------------------
// writeback_bypass_match
// Searches the occupied part of the writeback queue for the youngest entry
// whose address equals one read-port address.
//   entries      : queue storage, indexed by physical slot
//   head         : slot holding the oldest occupied entry
//   count        : number of occupied entries
//   read_address : operand address being read from the register file
//   hit          : some occupied entry targets read_address
//   data         : data of the youngest such entry, 0 when no hit
// ---------------------------------------------------------------------------
module writeback_bypass_match
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t                 entries [DEPTH],
    input  logic [PTR_W-1:0]          head,
    input  logic [CNT_W-1:0]          count,
    input  logic [REG_ADDR_W-1:0]     read_address,
    output logic                      hit,
    output logic [REG_DATA_MAX_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so a later match overrides an earlier
    // one; the slot index wraps naturally in PTR_W bits.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int age = 0; age < DEPTH; age++) begin
            if (age < int'(count)) begin
                idx = head + PTR_W'(age);
                if (entries[idx].addr == read_address) begin
                    hit  = 1'b1;
                    data = entries[idx].data;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
// In-order FIFO of pending register-file writes. Producers offer
// {address, data}; the head entry is written to the register file whenever
// the write port is free (inp_hold low). Optional operand forwarding of
// pending writes is compiled in when WRITEBACK_BYPASS_EN is defined;
// otherwise the bypass outputs are tied to 0.
//
// Parameters: W (data width, <= REG_DATA_MAX_W), DEPTH (power of two, 2..16)
// Ports:
//   clk, reset_synchronous          : clock, synchronous active-low reset
//   inp_valid / inp_ready           : offer handshake
//   inp_write_address/_data         : the offered writeback
//   inp_hold                        : register-file write port busy
//   out_write_enable/_address/_data : register-file write port
//   out_count                       : occupied entries
//   inp_read_address0/1             : operand read addresses
//   out_bypass_hit0/1, _data0/1     : forwarding of youngest pending write
// ---------------------------------------------------------------------------
module writeback_queue
    import regfile_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_synchronous,
    input  logic                    inp_valid,
    output logic                    inp_ready,
    input  logic [REG_ADDR_W-1:0]   inp_write_address,
    input  logic [W-1:0]            inp_write_data,
    input  logic                    inp_hold,
    output logic                    out_write_enable,
    output logic [REG_ADDR_W-1:0]   out_write_address,
    output logic [W-1:0]            out_write_data,
    output logic [$clog2(DEPTH):0]  out_count,
    input  logic [REG_ADDR_W-1:0]   inp_read_address0,
    input  logic [REG_ADDR_W-1:0]   inp_read_address1,
    output logic                    out_bypass_hit0,
    output logic                    out_bypass_hit1,
    output logic [W-1:0]            out_bypass_data0,
    output logic [W-1:0]            out_bypass_data1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        entries [DEPTH];
    wb_entry_t        new_entry;
    wb_entry_t        head_entry;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             not_empty;
    logic             full;
    logic             push;
    logic             pop;

    // Widen the offered data into the shared entry format.
    always_comb begin
        new_entry             = '0;
        new_entry.addr        = inp_write_address;
        new_entry.data[W-1:0] = inp_write_data;
    end

    assign not_empty  = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign head_entry = entries[head_ptr];

    // Readiness looks only at the current count, so a full queue refuses an
    // offer even in a cycle where the head is being drained.
    assign inp_ready        = reset_synchronous & ~full;
    assign out_write_enable = reset_synchronous & not_empty & ~inp_hold;
    assign push             = inp_valid & inp_ready;
    assign pop              = out_write_enable;
    assign out_count        = count;

    // Head entry is presented only when something is queued and the block
    // is out of reset.
    always_comb begin
        out_write_address = '0;
        out_write_data    = '0;
        if (reset_synchronous && not_empty) begin
            out_write_address = head_entry.addr;
            out_write_data    = head_entry.data[W-1:0];
        end
    end

    // Pointers and occupancy; reset discards anything pushed or popped in
    // the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_synchronous) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_ptr] <= new_entry;
        end
    end

    if (W < REG_DATA_MAX_W) begin : g_head_upper
        logic unused_head_upper;
        assign unused_head_upper = ^head_entry.data[REG_DATA_MAX_W-1:W];
    end

`ifdef WRITEBACK_BYPASS_EN
    logic                      match_hit0;
    logic                      match_hit1;
    logic [REG_DATA_MAX_W-1:0] match_data0;
    logic [REG_DATA_MAX_W-1:0] match_data1;

    writeback_bypass_match #(.DEPTH(DEPTH)) u_match0 (
        .entries      (entries),
        .head         (head_ptr),
        .count        (count),
        .read_address (inp_read_address0),
        .hit          (match_hit0),
        .data         (match_data0)
    );

    writeback_bypass_match #(.DEPTH(DEPTH)) u_match1 (
        .entries      (entries),
        .head         (head_ptr),
        .count        (count),
        .read_address (inp_read_address1),
        .hit          (match_hit1),
        .data         (match_data1)
    );

    assign out_bypass_hit0  = reset_synchronous & match_hit0;
    assign out_bypass_hit1  = reset_synchronous & match_hit1;
    assign out_bypass_data0 = reset_synchronous ? match_data0[W-1:0] : '0;
    assign out_bypass_data1 = reset_synchronous ? match_data1[W-1:0] : '0;

    if (W < REG_DATA_MAX_W) begin : g_match_upper
        logic unused_match_upper;
        assign unused_match_upper = ^{match_data0[REG_DATA_MAX_W-1:W],
                                      match_data1[REG_DATA_MAX_W-1:W]};
    end
`else
    logic unused_read_address;
    assign unused_read_address = ^{inp_read_address0, inp_read_address1};

    assign out_bypass_hit0  = 1'b0;
    assign out_bypass_hit1  = 1'b0;
    assign out_bypass_data0 = '0;
    assign out_bypass_data1 = '0;
`endif

endmodule
